serial_pattern_tx: RTL

Serial bit-pattern transmitter: the driving end of the single-bit serial stimulus line that the lab sequence-detector FSMs sample on their `x` input.

- Loads a pattern of up to MAX_LEN bits, a length, a bit period and a repeat count.
- Shifts the pattern out MSB-first, one bit per programmable bit period, and can repeat it back-to-back.
- Reports progress with a busy/done/strobe handshake.
- Sits between the board switch/button front end and the detector under test, replacing hand-toggled switches with deterministic sequences.

---
 rtl/serial_pattern_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first on ser_out_o,
// one bit per programmable period, optionally repeated back-to-back.
module serial_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int DIV_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [DIV_W-1:0]   bit_div_i,
    input  logic [7:0]         reps_i,
    output logic               ser_out_o,
    output logic               bit_strobe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [LEN_W-1:0]   bit_idx_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [7:0]         rep_cnt_q;
    logic [LEN_W-1:0]   bit_idx_q;
    logic               busy_q;
    logic               done_q;
    logic               strobe_q;

    logic [LEN_W-1:0]   len_d;
    logic [MAX_LEN-1:0] pat_shift;

    // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
    always_comb begin
        len_d = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            rep_cnt_q <= '0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pat_q     <= pattern_i;
                        len_q     <= len_d;
                        div_q     <= bit_div_i;
                        rep_cnt_q <= reps_i;
                        div_cnt_q <= '0;
                        if (len_d != '0) begin
                            state_q   <= SHIFT;
                            bit_idx_q <= len_d - LEN_W'(1);
                            busy_q    <= 1'b1;
                            strobe_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        bit_idx_q <= '0;
                        div_cnt_q <= '0;
                        rep_cnt_q <= '0;
                    end else if (div_cnt_q == div_q) begin
                        div_cnt_q <= '0;
                        if (bit_idx_q != '0) begin
                            bit_idx_q <= bit_idx_q - LEN_W'(1);
                            strobe_q  <= 1'b1;
                        end else if (rep_cnt_q != 8'd0) begin
                            // Reload for the next repetition with no idle gap.
                            rep_cnt_q <= rep_cnt_q - 8'd1;
                            bit_idx_q <= len_q - LEN_W'(1);
                            strobe_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Variable shift avoids a mismatched-width bit select on the shadow pattern.
    assign pat_shift    = pat_q >> bit_idx_q;
    assign ser_out_o    = (state_q == SHIFT) & pat_shift[0];
    assign bit_idx_o    = bit_idx_q;
    assign bit_strobe_o = strobe_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
